// File: rtl/icache_refill.sv
// Instruction cache line refill: fetches eight bus words for one 32-byte line
// and hands the assembled line to the fetch stage's cache write port.
module icache_refill #(
    parameter int PADDR_WIDTH = 32,
    parameter int VLEN        = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   stall,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [VLEN-6:0]        req_vaddr,
    input  logic [PADDR_WIDTH-6:0] req_paddr,
    input  logic                   abort,
    output logic                   done,
    output logic                   error,
    output logic                   mem_req,
    output logic [PADDR_WIDTH-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_err,
    output logic [VLEN-1:5]        cache_port_addr,
    output logic [7:0][31:0]       cache_port_data,
    output logic                   cache_port_set
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             beat_q, beat_d;
    logic [PADDR_WIDTH-6:0] base_q, base_d;
    logic [VLEN-1:5]        vaddr_q, vaddr_d;
    logic [7:0][31:0]       data_q, data_d;
    logic                   err_q, err_d;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        vaddr_d = vaddr_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    vaddr_d = req_vaddr;
                    base_d  = req_paddr;
                    beat_d  = 3'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // An aborted beat still has to finish its bus handshake.
                if (abort) begin
                    state_d = mem_ack ? IDLE : DRAIN;
                end else if (mem_ack) begin
                    if (mem_err) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        data_d[beat_q] = mem_rdata;
                        beat_d         = beat_q + 3'd1;
                        if (beat_q == 3'd7) state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (abort || !stall) state_d = IDLE;
            end
            DRAIN: begin
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            vaddr_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            vaddr_q <= vaddr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign mem_req         = (state_q == FETCH) || (state_q == DRAIN);
    assign mem_addr        = mem_req ? {base_q, beat_q, 2'b00} : '0;
    assign cache_port_set  = (state_q == WRITE) && !abort;
    assign done            = (state_q == WRITE) && !abort && !stall;
    assign error           = err_q;
    assign cache_port_addr = vaddr_q;
    assign cache_port_data = data_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: a per-cycle vector table for the nominal
// refill plus hand sequences for waits, stall, errors, aborts and reset.
module tb_icache_refill;

    logic         clock;
    logic         reset_n;
    logic         stall;
    logic         req_valid;
    logic         req_ready;
    logic [26:0]  req_vaddr;
    logic [26:0]  req_paddr;
    logic         abort;
    logic         done;
    logic         error;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic         mem_err;
    logic [31:5]  cache_port_addr;
    logic [7:0][31:0] cache_port_data;
    logic         cache_port_set;

    icache_refill dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_vaddr       (req_vaddr),
        .req_paddr       (req_paddr),
        .abort           (abort),
        .done            (done),
        .error           (error),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .mem_err         (mem_err),
        .cache_port_addr (cache_port_addr),
        .cache_port_data (cache_port_data),
        .cache_port_set  (cache_port_set)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rv;
        logic        ack;
        logic [31:0] rd;
        logic        rdy;
        logic        mreq;
        logic [31:0] addr;
        logic        set;
        logic        dn;
    } vec_t;

    vec_t tbl [11];

    int errors = 0;
    int checks = 0;
    int done_cnt;
    int err_cnt;
    logic set_seen;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then sample outputs.
    task automatic step(input logic rv, input logic ack, input logic err,
                        input logic stl, input logic ab,
                        input logic [31:0] rd);
        @(negedge clock);
        req_valid = rv;
        mem_ack   = ack;
        mem_err   = err;
        stall     = stl;
        abort     = ab;
        mem_rdata = rd;
        #1;
        if (cache_port_set) set_seen = 1'b1;
        if (done) done_cnt++;
        if (error) err_cnt++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic clr();
        done_cnt = 0;
        err_cnt  = 0;
        set_seen = 1'b0;
    endtask

    task automatic request(input logic [26:0] pa, input logic [26:0] va);
        req_paddr = pa;
        req_vaddr = va;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic beat_ok(input logic [31:0] rd);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rd);
    endtask

    initial begin
        for (int i = 0; i < 11; i++) begin
            tbl[i] = '{rv: 1'b0, ack: 1'b0, rd: 32'h0, rdy: 1'b0,
                       mreq: 1'b0, addr: 32'h0, set: 1'b0, dn: 1'b0};
        end
        tbl[0].rv  = 1'b1;
        tbl[0].rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tbl[i].ack  = 1'b1;
            tbl[i].rd   = 32'hA0 + 32'(i - 1);
            tbl[i].mreq = 1'b1;
            tbl[i].addr = 32'h2000 + 32'(4 * (i - 1));
        end
        tbl[9].set  = 1'b1;
        tbl[9].dn   = 1'b1;
        tbl[10].rdy = 1'b1;

        reset_n   = 1'b0;
        stall     = 1'b0;
        req_valid = 1'b0;
        req_vaddr = '0;
        req_paddr = '0;
        abort     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_err   = 1'b0;
        clr();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_mreq", 64'(mem_req), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_set", 64'(cache_port_set), 64'd0);
        chk("rst_done_err", 64'({done, error}), 64'd0);
        chk("rst_cpaddr", 64'(cache_port_addr), 64'd0);
        chk("rst_data_zero", 64'(cache_port_data == '0), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Nominal zero-wait refill, cycle by cycle from the table.
        req_paddr = 27'h100;
        req_vaddr = 27'h0ABCDEF;
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rv, tbl[i].ack, 1'b0, 1'b0, 1'b0, tbl[i].rd);
            chk($sformatf("nom_ready[%0d]", i), 64'(req_ready), 64'(tbl[i].rdy));
            chk($sformatf("nom_mreq[%0d]", i), 64'(mem_req), 64'(tbl[i].mreq));
            if (tbl[i].mreq)
                chk($sformatf("nom_addr[%0d]", i), 64'(mem_addr), 64'(tbl[i].addr));
            chk($sformatf("nom_set[%0d]", i), 64'(cache_port_set), 64'(tbl[i].set));
            chk($sformatf("nom_done[%0d]", i), 64'(done), 64'(tbl[i].dn));
            chk($sformatf("nom_err[%0d]", i), 64'(error), 64'd0);
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("nom_data[%0d]", i), 64'(cache_port_data[i]),
                64'(32'hA0 + 32'(i)));
        chk("nom_cpaddr", 64'(cache_port_addr), 64'h0ABCDEF);

        // Three-cycle ack latency, then four stalled WRITE cycles.
        clr();
        request(27'h200, 27'h1111111);
        for (int b = 0; b < 8; b++) begin
            for (int w = 0; w < 3; w++) begin
                step(1'b0, w == 2, 1'b0, 1'b0, 1'b0, 32'hB0 + 32'(b));
                chk($sformatf("ws_mreq[%0d.%0d]", b, w), 64'(mem_req), 64'd1);
                chk($sformatf("ws_addr[%0d.%0d]", b, w), 64'(mem_addr),
                    64'(32'h4000 + 32'(4 * b)));
            end
        end
        for (int s = 0; s < 4; s++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            chk($sformatf("st_set[%0d]", s), 64'(cache_port_set), 64'd1);
            chk($sformatf("st_done[%0d]", s), 64'(done), 64'd0);
        end
        idle();
        chk("st_set_final", 64'(cache_port_set), 64'd1);
        chk("st_done_final", 64'(done), 64'd1);
        idle();
        chk("st_ready_after", 64'(req_ready), 64'd1);
        chk("st_done_count", 64'(done_cnt), 64'd1);
        chk("st_data7", 64'(cache_port_data[7]), 64'hB7);

        // Bus error on beat 3.
        clr();
        request(27'h300, 27'h2222222);
        for (int b = 0; b < 3; b++) beat_ok(32'hC0 + 32'(b));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hBAD);
        chk("err_beat3_addr", 64'(mem_addr), 64'h600C);
        idle();
        chk("err_pulse", 64'(error), 64'd1);
        chk("err_no_beat4", 64'(mem_req), 64'd0);
        chk("err_ready", 64'(req_ready), 64'd1);
        idle();
        chk("err_pulse_end", 64'(error), 64'd0);
        chk("err_count", 64'(err_cnt), 64'd1);
        chk("err_no_set", 64'(set_seen), 64'd0);
        chk("err_no_done", 64'(done_cnt), 64'd0);

        // Abort while beat 5 waits; the beat drains, then a fresh refill.
        clr();
        request(27'h400, 27'h3333333);
        for (int b = 0; b < 5; b++) beat_ok(32'hC0 + 32'(b));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("ab_mreq_at_abort", 64'(mem_req), 64'd1);
        chk("ab_addr_at_abort", 64'(mem_addr), 64'h8014);
        idle();
        chk("ab_drain_mreq", 64'(mem_req), 64'd1);
        chk("ab_drain_addr", 64'(mem_addr), 64'h8014);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD);
        chk("ab_ack_mreq", 64'(mem_req), 64'd1);
        idle();
        chk("ab_mreq_drop", 64'(mem_req), 64'd0);
        chk("ab_ready", 64'(req_ready), 64'd1);
        chk("ab_no_flags", 64'({set_seen, 1'(done_cnt != 0), 1'(err_cnt != 0)}), 64'd0);
        chk("ab_data5_kept", 64'(cache_port_data[5]), 64'hB5);
        request(27'h500, 27'h4444444);
        for (int b = 0; b < 8; b++) beat_ok(32'hD0 + 32'(b));
        idle();
        chk("ab2_set", 64'(cache_port_set), 64'd1);
        chk("ab2_done", 64'(done), 64'd1);
        idle();
        chk("ab2_ready", 64'(req_ready), 64'd1);
        chk("ab2_data5", 64'(cache_port_data[5]), 64'hD5);
        chk("ab2_cpaddr", 64'(cache_port_addr), 64'h4444444);

        // Abort in a stalled WRITE.
        clr();
        request(27'h600, 27'h5555555);
        for (int b = 0; b < 8; b++) beat_ok(32'hE0 + 32'(b));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("aw_set", 64'(cache_port_set), 64'd0);
        chk("aw_done", 64'(done), 64'd0);
        idle();
        chk("aw_ready", 64'(req_ready), 64'd1);
        chk("aw_idle_set", 64'(cache_port_set), 64'd0);
        chk("aw_done_count", 64'(done_cnt), 64'd0);

        // Asynchronous reset during beat 2.
        clr();
        request(27'h700, 27'h6666666);
        beat_ok(32'hF0);
        beat_ok(32'hF1);
        idle();
        chk("rm_beat2_addr", 64'(mem_addr), 64'hE008);
        reset_n = 1'b0;
        #1;
        chk("rm_ready", 64'(req_ready), 64'd1);
        chk("rm_mreq", 64'(mem_req), 64'd0);
        chk("rm_addr", 64'(mem_addr), 64'd0);
        chk("rm_set_done_err", 64'({cache_port_set, done, error}), 64'd0);
        chk("rm_cpaddr", 64'(cache_port_addr), 64'd0);
        chk("rm_data_zero", 64'(cache_port_data == '0), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        idle();
        chk("rm_ready_after", 64'(req_ready), 64'd1);
        chk("rm_mreq_after", 64'(mem_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
# icache_refill

Instruction cache refill engine: on request from the execute stage after an instruction cache miss, it reads one 32-byte line (8 × 32-bit words) from the memory bus and then writes it into the fetch stage's instruction cache through the fetch stage's cache port. It drives `cache_port_addr`, `cache_port_data` and `cache_port_set` directly. The fetch stage handles compressed-instruction preprocessing, tagging and the post-write bubble, so this block delivers raw bus words.

## Interface
Parameters:
- `PADDR_WIDTH`, default 32: physical byte-address width of the memory bus.

Ports:
- `clock`  in  1  — single clock, all state on rising edge.
- `reset_n`  in  1  — reset, asynchronous, active-low.
- `stall`  in  1  — pipeline stall; the same signal the fetch stage sees.
- `req_valid`  in  1  — refill request.
- `req_ready`  out  1  — high only in IDLE.
- `req_vaddr`  in  `VLEN-5`  — virtual line address `[VLEN-1:5]` (cache tag/index).
- `req_paddr`  in  `PADDR_WIDTH-5`  — physical line address.
- `abort`  in  1  — cancel the in-flight refill (redirect/flush).
- `done`  out  1  — one-cycle pulse when the line is written.
- `error`  out  1  — one-cycle pulse on a bus error; no write occurs.
- `mem_req`  out  1  — bus read request, one word per beat.
- `mem_addr`  out  `PADDR_WIDTH`  — byte address, `[1:0]`=0.
- `mem_ack`  in  1  — beat complete; `mem_rdata`/`mem_err` valid.
- `mem_rdata`  in  32  — read data.
- `mem_err`  in  1  — access fault; qualified by `mem_ack`.
- `cache_port_addr`  out  `VLEN-1:5`  — to fetch stage.
- `cache_port_data`  out  `[7:0][31:0]`  — word i at byte offset 4·i.
- `cache_port_set`  out  1  — to fetch stage.

## Operation
- States: IDLE, FETCH, WRITE, DRAIN.
- IDLE:
  - On `req_valid`, latch `req_vaddr` into `cache_port_addr` and `req_paddr` into the line base.
  - Clear `beat` (3-bit) and the `aborted`/`err` flags, then go to FETCH.
  - `abort` in IDLE is ignored.
- FETCH:
  - `mem_req`=1 and `mem_addr`={line_base, beat, 2'b00}.
  - On `mem_ack`, store `mem_rdata` into `cache_port_data[beat]`, then increment `beat`.
  - On `mem_ack` with `beat`==7 and no `mem_err`, go to WRITE.
- Error handling:
  - `mem_ack` with `mem_err`=1: `error` pulses next cycle and the state goes to IDLE.
  - Remaining beats are not issued and there is no write.
- Bus handshake:
  - Once `mem_req` is asserted, `mem_req` and `mem_addr` are held stable until `mem_ack`.
  - `mem_ack` while `mem_req`=0 is ignored.
- `abort` in FETCH:
  - If `mem_req` is mid-beat, go to DRAIN: keep the beat until `mem_ack`, discard the data, then go to IDLE.
  - No `done`, no `error` (including if `mem_err` arrives on the drained beat), no write.
- WRITE:
  - `cache_port_set`=1.
  - If `stall`=0, `done` pulses the same cycle and the state goes to IDLE next cycle.
  - If `stall`=1, stay in WRITE with `cache_port_set` held; the fetch stage ignores it while stalled.
- `abort` in WRITE: `cache_port_set` is forced to 0 that cycle, the state goes to IDLE, and there is no `done`.
- `abort` takes precedence over `mem_ack`/`mem_err` in the same cycle, except for completing the bus handshake.
- Buffer behaviour:
  - `cache_port_data` and `cache_port_addr` change only on request accept and on data beats.
  - Stale words are never written, because a write only follows 8 successful beats.
- `beat` wraps 7→0 only on the transition to WRITE; it is not observed outside FETCH.
- `stall` does not pause bus beats; it only holds WRITE.

## Timing
- Reset (async assert, sync deassert by the surrounding reset logic) puts the state in IDLE.
- Output values in reset:
  - `req_ready`=1
  - `mem_req`=0, `mem_addr`=0
  - `cache_port_set`=0, `cache_port_addr`=0, `cache_port_data`=0
  - `done`=0, `error`=0
- Reset mid-refill drops the beat without a handshake. The memory subsystem shares `reset_n`.
- Accept at cycle 0; `mem_req` rises in cycle 1.
- With `mem_ack` on the same cycle each beat: beats in cycles 1–8, `cache_port_set`/`done` in cycle 9, `req_ready`=1 in cycle 10.
- Minimum refill latency is 10 cycles from accept to ready.
- Between beats, `mem_addr` advances the cycle after the ack and `mem_req` stays high, so back-to-back beats run at one word/cycle.
- `done`/`error` are single-cycle pulses and never assert together.
- `req_ready` is combinational from state only.

## Test plan
- **Nominal refill:**
  - Stimulus: `req_paddr`=0x0000_0100 (line 0x2000), zero-wait bus returning 0xA0+i.
  - Required: addresses 0x2000..0x201C in cycles 1–8; `cache_port_set`+`done` in cycle 9 with data[i]=0xA0+i.
- **Wait states and stall:**
  - Stimulus: 3-cycle ack latency per beat, and `stall`=1 for 4 cycles when WRITE is reached.
  - Required: `mem_addr` is stable during waits; `cache_port_set` is held 5 cycles; `done` pulses only once, in the first unstalled cycle.
- **Bus error:**
  - Stimulus: `mem_err` on beat 3.
  - Required: no beat 4 request; `error` pulses once; `cache_port_set` never asserts; `req_ready`=1 next cycle.
- **Abort mid-beat:**
  - Stimulus: `abort` while beat 5 is waiting.
  - Required: `mem_req` is held until ack, then drops; no `done`, `error` or `cache_port_set`; a new request is accepted afterwards and completes normally.
- **Abort in WRITE:**
  - Stimulus: `abort` with `stall`=1 in WRITE.
  - Required: `cache_port_set`=0 that cycle, IDLE next cycle, no `done`.
- **Reset mid-FETCH:**
  - Stimulus: assert `reset_n`=0 during beat 2.
  - Required: all outputs reach their reset values asynchronously; `req_ready`=1.
